rom_load_ctrl: RTL

ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

---
 rtl/rom_load_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/rom_load_ctrl.sv
// HPS ROM download controller: routes download bytes to CPU/GFX/SND regions and sequences core reset.
// Optional checksum check is enabled by defining ROM_CHECKSUM_EN.
module rom_load_ctrl #(
    parameter logic [17:0] ROM_BYTES     = 18'h14000,
    parameter logic [16:0] CPU_END       = 17'h0C000,
    parameter logic [16:0] GFX_END       = 17'h13000,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter logic [7:0]  ROM_SUM       = 8'h00
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [16:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic        cpu_wr,
    output logic        gfx_wr,
    output logic        snd_wr,
    output logic [16:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        core_reset,
    output logic        load_ok,
    output logic        load_err,
    output logic [7:0]  chk_sum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_ERROR
    } state_t;

    state_t      state, state_next;
    logic        dl_q;
    logic        dl_rise;
    logic        in_range;
    logic        accept;
    logic        reject;
    logic        load_entry;
    logic        sum_ok;
    logic [17:0] byte_cnt, cnt_next;
    logic        overflow, ovf_next;
    logic [7:0]  settle_cnt;
    logic        sel_cpu, sel_gfx, sel_snd;
    logic [16:0] rel_addr;

    assign dl_rise    = ioctl_download & ~dl_q;
    assign in_range   = ({1'b0, ioctl_addr} < ROM_BYTES);
    assign accept     = (state == S_LOAD) & ioctl_wr & in_range;
    assign reject     = (state == S_LOAD) & ioctl_wr & ~in_range;
    assign load_entry = (state_next == S_LOAD) && (state != S_LOAD);

    // The write sampled with the download fall is folded in before the end-of-load verdict.
    always_comb begin
        cnt_next = byte_cnt;
        if (accept && (byte_cnt != '1))
            cnt_next = byte_cnt + 18'd1;
        ovf_next = overflow | reject;
    end

    always_comb begin
        sel_cpu  = 1'b0;
        sel_gfx  = 1'b0;
        sel_snd  = 1'b0;
        rel_addr = ioctl_addr;
        if (ioctl_addr < CPU_END) begin
            sel_cpu = 1'b1;
        end else if (ioctl_addr < GFX_END) begin
            sel_gfx  = 1'b1;
            rel_addr = ioctl_addr - CPU_END;
        end else begin
            sel_snd  = 1'b1;
            rel_addr = ioctl_addr - GFX_END;
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [7:0] sum_q, sum_next;

    assign sum_next = accept ? (sum_q + ioctl_dout) : sum_q;
    assign sum_ok   = (sum_next == ROM_SUM);
    assign chk_sum  = sum_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            sum_q <= '0;
        else if (load_entry)
            sum_q <= '0;
        else
            sum_q <= sum_next;
    end
`else
    logic unused_rom_sum;

    assign unused_rom_sum = ^ROM_SUM;
    assign sum_ok         = 1'b1;
    assign chk_sum        = '0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (dl_rise)
                    state_next = S_LOAD;
            end
            S_LOAD: begin
                if (!ioctl_download) begin
                    if ((cnt_next == ROM_BYTES) && !ovf_next && sum_ok)
                        state_next = S_SETTLE;
                    else
                        state_next = S_ERROR;
                end
            end
            S_SETTLE: begin
                if (dl_rise)
                    state_next = S_LOAD;
                else if (settle_cnt <= 8'd1)
                    state_next = S_RUN;
            end
            S_RUN: begin
                if (dl_rise)
                    state_next = S_LOAD;
                else if (user_reset)
                    state_next = S_SETTLE;
            end
            S_ERROR: begin
                if (dl_rise)
                    state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // dl_q resets high so a download held across reset is not mistaken for a new one.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            dl_q  <= 1'b1;
        end else begin
            state <= state_next;
            dl_q  <= ioctl_download;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt   <= '0;
            overflow   <= 1'b0;
            settle_cnt <= '0;
        end else begin
            if (load_entry) begin
                byte_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                byte_cnt <= cnt_next;
                overflow <= ovf_next;
            end
            if ((state_next == S_SETTLE) && (state != S_SETTLE))
                settle_cnt <= 8'(SETTLE_CYCLES);
            else if ((state == S_SETTLE) && (settle_cnt != '0))
                settle_cnt <= settle_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cpu_wr     <= 1'b0;
            gfx_wr     <= 1'b0;
            snd_wr     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            core_reset <= 1'b1;
            load_ok    <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            cpu_wr     <= accept & sel_cpu;
            gfx_wr     <= accept & sel_gfx;
            snd_wr     <= accept & sel_snd;
            core_reset <= (state != S_RUN);
            if (accept) begin
                wr_addr <= rel_addr;
                wr_data <= ioctl_dout;
            end
            if (load_entry) begin
                load_ok  <= 1'b0;
                load_err <= 1'b0;
            end else if (state == S_LOAD) begin
                if (state_next == S_SETTLE)
                    load_ok <= 1'b1;
                if (state_next == S_ERROR)
                    load_err <= 1'b1;
            end
        end
    end

endmodule
